// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: oversampling ratio,
// receiver FSM states, line-format encodings and the layout of a FIFO entry.
package uart_pkg;

  localparam int OS_TICKS = 16;
  localparam int ENTRY_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_t;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } data_bits_t;

  // One received character as stored in the FIFO.
  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } entry_t;

  // Index of the last data bit of a frame (5 bits -> 4 ... 8 bits -> 7).
  function automatic logic [2:0] last_bit_idx(data_bits_t db);
    return 3'(db) + 3'd4;
  endfunction

  function automatic logic parity_on(parity_t p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Configuration, serial input and FIFO read-side signals of the UART receiver.
interface uart_rx_cfg_if #(
  parameter int DVSR_W = 11
);
  logic              rx;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        data_bits;
  logic [1:0]        parity_mode;
  logic              stop_bits;
  logic              r_uart;
  logic              ovr_clr;
  logic [7:0]        r_data;
  logic              parity_err;
  logic              frame_err;
  logic              rx_empty;
  logic              rx_full;
  logic              overrun;

  // Host / line side: drives serial line and configuration, reads characters.
  modport master (
    output rx, dvsr, data_bits, parity_mode, stop_bits, r_uart, ovr_clr,
    input  r_data, parity_err, frame_err, rx_empty, rx_full, overrun
  );

  // Receiver side.
  modport slave (
    input  rx, dvsr, data_bits, parity_mode, stop_bits, r_uart, ovr_clr,
    output r_data, parity_err, frame_err, rx_empty, rx_full, overrun
  );
endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for received characters with a sticky
// overrun flag. Full/empty come from pointers carrying one extra wrap bit.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int W  = 2,
  parameter int DW = ENTRY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  input  logic          ovr_clr,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic          overrun
);

  logic [DW-1:0] mem [2**W];
  logic [W:0]    wr_ptr, rd_ptr;
  logic          do_rd, do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[W] != rd_ptr[W]) && (wr_ptr[W-1:0] == rd_ptr[W-1:0]);

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when the head is popped in the same cycle (the freed slot is reused).
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Head is presented combinationally; zero while nothing is stored.
  assign rd_data = empty ? '0 : mem[rd_ptr[W-1:0]];

  // Storage array write.
  // NOTE: storage is deliberately not reset -- empty/full gate every read, so
  // stale contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[W-1:0]] <= wr_data;
  end

  // Pointer update; both pointers wrap naturally modulo 2**(W+1).
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (W+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (W+1)'(1);
    end
  end

  // Sticky overrun: a dropped write sets it and wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                           overrun <= 1'b0;
    else if (wr && full && !do_rd)     overrun <= 1'b1;
    else if (ovr_clr)                  overrun <= 1'b0;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time selectable data length, parity and stop bits.
// A baud tick generator drives a 16x oversampling FSM; finished characters
// (with their error bits) are queued in a small FWFT FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int W      = 2,
  parameter int DVSR_W = 11
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.slave  bus
);

  localparam logic [3:0] S_MID  = 4'(OS_TICKS/2 - 1);
  localparam logic [3:0] S_LAST = 4'(OS_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------------
  logic [DVSR_W-1:0] tick_cnt;
  logic              tick;

  // Using >= rather than == lets the counter recover at once if dvsr is
  // lowered below the current count instead of running through a full wrap.
  assign tick = (tick_cnt >= bus.dvsr);

  // Free-running divider: one tick every dvsr+1 clocks.
  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + DVSR_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] s_q, s_d;          // oversample ticks within the current bit
  logic [2:0] n_q, n_d;          // data bit index, reused as stop bit index
  logic [7:0] data_q, data_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  data_bits_t db_q, db_d;        // format latched at start-bit detection
  parity_t    par_q, par_d;
  logic       sb_q, sb_d;

  logic       fifo_wr;
  entry_t     wr_entry;
  entry_t     head;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      db_q    <= BITS_8;
      par_q   <= PAR_NONE;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      db_q    <= db_d;
      par_q   <= par_d;
      sb_q    <= sb_d;
    end
  end

  // Next-state, bit sampling and FIFO write strobe.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    data_d   = data_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    db_d     = db_q;
    par_d    = par_q;
    sb_d     = sb_q;
    fifo_wr  = 1'b0;
    wr_entry = '0;

    unique case (state_q)
      IDLE: begin
        if (!bus.rx) begin
          state_d = START;
          s_d     = '0;
          data_d  = '0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
          db_d    = data_bits_t'(bus.data_bits);
          par_d   = parity_t'(bus.parity_mode);
          sb_d    = bus.stop_bits;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            // Still low at mid-bit: a real start bit, otherwise a glitch.
            if (!bus.rx) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d         = '0;
            data_d[n_q] = bus.rx;   // LSB first, lands right-justified
            n_d         = n_q + 3'd1;
            if (n_q == last_bit_idx(db_q)) begin
              state_d = parity_on(par_q) ? PARITY : STOP;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = STOP;
            // Unused data MSBs are zero, so ^data_q covers only real bits.
            pe_d    = (par_q == PAR_EVEN) ? (bus.rx != ^data_q)
                                          : (bus.rx != ~^data_q);
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d  = '0;
            fe_d = fe_q | ~bus.rx;
            if (n_q[0] == sb_q) begin
              fifo_wr  = 1'b1;
              wr_entry = '{frame_err: fe_q | ~bus.rx, parity_err: pe_q, data: data_q};
              state_d  = IDLE;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  uart_fifo #(
    .W  (W),
    .DW (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (fifo_wr),
    .wr_data (wr_entry),
    .rd      (bus.r_uart),
    .ovr_clr (bus.ovr_clr),
    .rd_data (head),
    .empty   (bus.rx_empty),
    .full    (bus.rx_full),
    .overrun (bus.overrun)
  );

  assign bus.r_data     = head.data;
  assign bus.parity_err = head.parity_err;
  assign bus.frame_err  = head.frame_err;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are bit-banged onto rx, the expected
// FIFO entry is queued when a frame is sent and compared when it is popped.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DVSR_W(11)) bus ();

  uart_rx_cfg #(
    .W      (2),
    .DVSR_W (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         compared   = 0;
  int         mismatched = 0;
  int         dvsr_val   = 3;
  logic [9:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive rx for a number of oversample ticks (inputs change on falling edges).
  task automatic hold(input logic v, input int ticks);
    bus.rx = v;
    repeat (ticks * (dvsr_val + 1)) @(negedge clk);
  endtask

  task automatic configure(input logic [1:0] db, input logic [1:0] pm,
                           input logic sb, input int dv);
    bus.data_bits   = db;
    bus.parity_mode = pm;
    bus.stop_bits   = sb;
    dvsr_val        = dv;
    bus.dvsr        = 11'(dv);
    hold(1'b1, 4);
  endtask

  // par: 0 none, 1 odd, 2 even. bad_stop drives the last stop bit low for
  // its first 10 ticks only, so the line is idle again before the receiver
  // could mistake it for a new start bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                            input bit bad_par, input int ns, input bit bad_stop,
                            input bit expect_write);
    logic [7:0] m;
    logic       p;
    m = d & ((8'd1 << nb) - 8'd1);
    hold(1'b0, 16);
    for (int i = 0; i < nb; i++) hold(d[i], 16);
    if (par != 0) begin
      p = (par == 2) ? ^m : ~^m;
      hold(p ^ bad_par, 16);
    end
    for (int i = 0; i < ns; i++) begin
      if (bad_stop && i == ns - 1) begin
        hold(1'b0, 10);
        hold(1'b1, 6);
      end else begin
        hold(1'b1, 16);
      end
    end
    if (expect_write) exp_q.push_back({bad_stop, (bad_par && par != 0), m});
    hold(1'b1, 2);
  endtask

  task automatic pulse_pop();
    bus.r_uart = 1'b1;
    @(negedge clk);
    bus.r_uart = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s_scoreboard: observed 0 queued expected at least 1", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_empty"}, bus.rx_empty, 1'b0);
    check({tag, "_data"},  bus.r_data, e[7:0]);
    check({tag, "_perr"},  bus.parity_err, e[8]);
    check({tag, "_ferr"},  bus.frame_err, e[9]);
    pulse_pop();
  endtask

  initial begin
    rst             = 1'b1;
    bus.rx          = 1'b1;
    bus.dvsr        = 11'd3;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop_bits   = 1'b0;
    bus.r_uart      = 1'b0;
    bus.ovr_clr     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_empty",   bus.rx_empty, 1'b1);
    check("rst_full",    bus.rx_full, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_data",    bus.r_data, 8'h00);
    check("rst_perr",    bus.parity_err, 1'b0);
    check("rst_ferr",    bus.frame_err, 1'b0);
    rst = 1'b0;

    // 8N1, dvsr=3
    configure(2'b11, 2'b00, 1'b0, 3);
    send_frame(8'hA5, 8, 0, 0, 1, 0, 1);
    pop_check("a5_8n1");
    check("a5_empty_after_pop", bus.rx_empty, 1'b1);

    // 7E1 with wrong parity bit
    configure(2'b10, 2'b10, 1'b0, 3);
    send_frame(8'h35, 7, 2, 1, 1, 0, 1);
    pop_check("35_7e1_badpar");

    // 8O1 with correct parity
    configure(2'b11, 2'b01, 1'b0, 3);
    send_frame(8'h96, 8, 1, 0, 1, 0, 1);
    pop_check("96_8o1");

    // 8N2, second stop bit low
    configure(2'b11, 2'b00, 1'b1, 3);
    send_frame(8'h3C, 8, 0, 0, 2, 1, 1);
    pop_check("3c_8n2_badstop");

    // Start-bit glitch: 4 ticks low, then idle
    configure(2'b11, 2'b00, 1'b0, 3);
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_empty", bus.rx_empty, 1'b1);

    // Fill FIFO then overflow it
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 0, 0, 1, 0, 1);
    check("fill4_full",    bus.rx_full, 1'b1);
    check("fill4_overrun", bus.overrun, 1'b0);
    send_frame(8'h05, 8, 0, 0, 1, 0, 0);
    check("ovf_full",    bus.rx_full, 1'b1);
    check("ovf_overrun", bus.overrun, 1'b1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("drain_%0d", i));
    check("drain_empty", bus.rx_empty, 1'b1);
    check("drain_full",  bus.rx_full, 1'b0);

    // Pop while empty is ignored; overrun stays until cleared
    pulse_pop();
    check("pop_empty_empty",   bus.rx_empty, 1'b1);
    check("pop_empty_data",    bus.r_data, 8'h00);
    check("overrun_sticky",    bus.overrun, 1'b1);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    check("ovr_clr", bus.overrun, 1'b0);

    // dvsr=0 (tick every clock), 6N1
    configure(2'b01, 2'b00, 1'b0, 0);
    send_frame(8'hC3, 6, 0, 0, 1, 0, 1);
    pop_check("c3_6n1_dvsr0");

    // Reset in the middle of DATA discards the partial frame
    configure(2'b11, 2'b00, 1'b0, 3);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 32);
    check("midrst_empty", bus.rx_empty, 1'b1);
    send_frame(8'h5A, 8, 0, 0, 1, 0, 1);
    pop_check("5a_after_rst");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
